// File: rtl/dk_sfx_sequencer.sv
// One-shot trigger scheduler for the discrete sound-effect enables, with a forced off-gap and a voice limit.
// Build option: define DK_SFX_PREEMPT_EN to let a request evict a lower-priority voice when the pool is full.
module dk_sfx_sequencer #(
    parameter int CLOCK_RATE   = 1000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int NUM_CH       = 4,
    parameter int HOLD_SAMPLES = 4800,
    parameter int GAP_SAMPLES  = 96,
    parameter int MAX_ACTIVE   = 2,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int CNT_W       = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              audio_clk_en,
    input  logic              trig_valid,
    output logic              trig_ready,
    input  logic [CH_W-1:0]   trig_ch,
    input  logic [15:0]       trig_len,
    output logic [NUM_CH-1:0] en,
    output logic              trig_drop,
    output logic [CNT_W-1:0]  active_count
);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("dk_sfx_sequencer: NUM_CH must be 2..8");
    end
    if (MAX_ACTIVE < 1 || MAX_ACTIVE > NUM_CH) begin : g_bad_max_active
        $error("dk_sfx_sequencer: MAX_ACTIVE must be 1..NUM_CH");
    end
    if (GAP_SAMPLES < 1 || GAP_SAMPLES > 65535 || HOLD_SAMPLES < 1 || HOLD_SAMPLES > 65535) begin : g_bad_len
        $error("dk_sfx_sequencer: GAP_SAMPLES and HOLD_SAMPLES must be 1..65535");
    end
    if (SAMPLE_RATE < 1 || CLOCK_RATE < SAMPLE_RATE) begin : g_bad_rate
        $error("dk_sfx_sequencer: sample ticks cannot outpace the system clock");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } ch_state_e;

    localparam logic [15:0] HOLD_LEN = 16'(HOLD_SAMPLES);
    localparam logic [15:0] GAP_LEN  = 16'(GAP_SAMPLES);

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [15:0]       cnt_q   [NUM_CH];
    logic [15:0]       cnt_d   [NUM_CH];
    logic              pend_q  [NUM_CH];
    logic              pend_d  [NUM_CH];
    logic [15:0]       plen_q  [NUM_CH];
    logic [15:0]       plen_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] en_d;
    logic              drop_q;
    logic              drop_d;

    logic              accept;
    logic              ch_valid;
    logic [15:0]       req_len;
    logic [NUM_CH-1:0] reserved;
    logic [CNT_W-1:0]  res_count;
    logic              slot_free;
    ch_state_e         sel_state;
    logic              sel_pend;
    logic              need_slot;
    logic              grant;

    // Requests are refused outright in tick cycles so timer updates and accepts never collide.
    assign trig_ready = reset_n & ~audio_clk_en;
    assign accept     = trig_valid & trig_ready;
    assign req_len    = (trig_len == 16'd0) ? HOLD_LEN : trig_len;
    assign ch_valid   = (int'(trig_ch) < NUM_CH);

    always_comb begin
        reserved  = '0;
        res_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            reserved[i] = (state_q[i] == S_ON) || ((state_q[i] == S_GAP) && pend_q[i]);
            res_count   = res_count + CNT_W'(reserved[i]);
        end
    end

    assign slot_free    = (int'(res_count) < MAX_ACTIVE);
    assign active_count = res_count;

    always_comb begin
        sel_state = S_IDLE;
        sel_pend  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_ch == CH_W'(i)) begin
                sel_state = state_q[i];
                sel_pend  = pend_q[i];
            end
        end
    end

    // A channel already holding a voice (ON, or GAP with a queued retrigger) keeps it without a new slot.
    assign need_slot = (sel_state == S_IDLE) || ((sel_state == S_GAP) && !sel_pend);

`ifdef DK_SFX_PREEMPT_EN
    logic            victim_found;
    logic [CH_W-1:0] victim_ch;

    always_comb begin
        victim_found = 1'b0;
        victim_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reserved[i] && (i > int'(trig_ch))) begin
                victim_found = 1'b1;
                victim_ch    = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        plen_d  = plen_q;
        drop_d  = 1'b0;
        grant   = 1'b0;
        en_d    = '0;

        if (audio_clk_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q[i] != S_IDLE) begin
                    if (cnt_q[i] == 16'd1) begin
                        if (state_q[i] == S_ON) begin
                            state_d[i] = S_GAP;
                            cnt_d[i]   = GAP_LEN;
                        end else if (pend_q[i]) begin
                            state_d[i] = S_ON;
                            cnt_d[i]   = plen_q[i];
                            pend_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = 16'd0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - 16'd1;
                    end
                end
            end
        end else if (accept) begin
            if (!ch_valid) begin
                drop_d = 1'b1;
            end else if (!need_slot || slot_free) begin
                grant = 1'b1;
            end
`ifdef DK_SFX_PREEMPT_EN
            else if (victim_found) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (victim_ch == CH_W'(i)) begin
                        state_d[i] = S_GAP;
                        cnt_d[i]   = GAP_LEN;
                        pend_d[i]  = 1'b0;
                    end
                end
                grant = 1'b1;
            end
`endif
            else begin
                drop_d = 1'b1;
            end

            if (grant) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (trig_ch == CH_W'(i)) begin
                        case (state_q[i])
                            S_IDLE: begin
                                state_d[i] = S_ON;
                                cnt_d[i]   = req_len;
                            end
                            S_ON: begin
                                state_d[i] = S_GAP;
                                cnt_d[i]   = GAP_LEN;
                                pend_d[i]  = 1'b1;
                                plen_d[i]  = req_len;
                            end
                            default: begin
                                pend_d[i] = 1'b1;
                                plen_d[i] = req_len;
                            end
                        endcase
                    end
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            en_d[i] = (state_d[i] == S_ON);
        end
    end

    // Enables come straight from flops so the analogue side never sees decode glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= 16'd0;
                pend_q[i]  <= 1'b0;
                plen_q[i]  <= 16'd0;
            end
            en_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            plen_q  <= plen_d;
            en_q    <= en_d;
            drop_q  <= drop_d;
        end
    end

    assign en        = en_q;
    assign trig_drop = drop_q;

endmodule

// File: tb/tb_dk_sfx_sequencer.sv
// Self-checking bench for dk_sfx_sequencer: a remaining-ticks model of every channel, checked each cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_dk_sfx_sequencer;

    localparam int NCH         = 4;
    localparam int HOLD        = 10;
    localparam int GAP         = 3;
    localparam int MAXA        = 2;
    localparam int TICK_PERIOD = 8;
`ifdef DK_SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        audio_clk_en;
    logic        trig_valid;
    logic        trig_ready;
    logic [1:0]  trig_ch;
    logic [15:0] trig_len;
    logic [3:0]  en;
    logic        trig_drop;
    logic [2:0]  active_count;

    logic        trig_valid5;
    logic        trig_ready5;
    logic [2:0]  trig_ch5;
    logic [15:0] trig_len5;
    logic [4:0]  en5;
    logic        trig_drop5;
    logic [2:0]  active_count5;

    int m_on   [NCH];
    int m_gap  [NCH];
    bit m_pend [NCH];
    int m_plen [NCH];
    bit m_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;
    int en_ticks [NCH];
    int drop_seen;

    dk_sfx_sequencer #(
        .CLOCK_RATE(1000000), .SAMPLE_RATE(48000), .NUM_CH(NCH),
        .HOLD_SAMPLES(HOLD), .GAP_SAMPLES(GAP), .MAX_ACTIVE(MAXA)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en),
        .trig_valid(trig_valid), .trig_ready(trig_ready), .trig_ch(trig_ch),
        .trig_len(trig_len), .en(en), .trig_drop(trig_drop), .active_count(active_count)
    );

    // Five-channel variant gives trig_ch a third bit, so out-of-range channel numbers can be driven.
    dk_sfx_sequencer #(
        .CLOCK_RATE(1000000), .SAMPLE_RATE(48000), .NUM_CH(5),
        .HOLD_SAMPLES(HOLD), .GAP_SAMPLES(GAP), .MAX_ACTIVE(MAXA)
    ) u_dut5 (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en),
        .trig_valid(trig_valid5), .trig_ready(trig_ready5), .trig_ch(trig_ch5),
        .trig_len(trig_len5), .en(en5), .trig_drop(trig_drop5), .active_count(active_count5)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit m_reserved(input int i);
        return (m_on[i] > 0) || ((m_gap[i] > 0) && m_pend[i]);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NCH; i++) if (m_reserved(i)) n++;
        return n;
    endfunction

    function automatic logic [3:0] m_en();
        logic [3:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (m_on[i] > 0);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_on[i] = 0; m_gap[i] = 0; m_pend[i] = 1'b0; m_plen[i] = 0;
        end
        m_drop = 1'b0;
    endfunction

    // Each channel is "ticks of sound left" followed by "ticks of silence left", plus an optional queued length.
    function automatic void model_step(input bit tick, input bit valid, input int c, input int len);
        bit new_drop = 1'b0;
        int l = (len == 0) ? HOLD : len;
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_on[i] > 0) begin
                    m_on[i]--;
                    if (m_on[i] == 0) m_gap[i] = GAP;
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                    if (m_gap[i] == 0 && m_pend[i]) begin
                        m_on[i] = m_plen[i];
                        m_pend[i] = 1'b0;
                    end
                end
            end
        end else if (valid) begin
            if (c >= NCH) begin
                new_drop = 1'b1;
            end else if (m_on[c] > 0) begin
                m_on[c] = 0; m_gap[c] = GAP; m_pend[c] = 1'b1; m_plen[c] = l;
            end else if (m_gap[c] > 0 && m_pend[c]) begin
                m_plen[c] = l;
            end else begin
                bit ok = (m_count() < MAXA);
                if (!ok && PREEMPT) begin
                    int v = -1;
                    for (int i = c + 1; i < NCH; i++) if (m_reserved(i)) v = i;
                    if (v >= 0) begin
                        m_on[v] = 0; m_gap[v] = GAP; m_pend[v] = 1'b0;
                        ok = 1'b1;
                    end
                end
                if (!ok) new_drop = 1'b1;
                else if (m_gap[c] > 0) begin
                    m_pend[c] = 1'b1; m_plen[c] = l;
                end else m_on[c] = l;
            end
        end
        m_drop = new_drop;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step(audio_clk_en, trig_valid, int'(trig_ch), int'(trig_len));
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) if (audio_clk_en && en[i]) en_ticks[i] = en_ticks[i] + 1;
        if (trig_drop) drop_seen = drop_seen + 1;
        if (cmp_en) begin
            check_output("en", en, m_en());
            check_output("trig_drop", trig_drop, m_drop);
            check_output("active_count", active_count, m_count());
            check_output("trig_ready", trig_ready, reset_n && !audio_clk_en);
        end
    end

    task automatic apply_stimulus(input bit v, input int ch, input int len);
        audio_clk_en = ((cyc % TICK_PERIOD) == TICK_PERIOD - 1);
        trig_valid   = v;
        trig_ch      = 2'(ch);
        trig_len     = 16'(len);
        #1;
        if (audio_clk_en && trig_valid) check_output("ready_in_tick", trig_ready, 0);
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 0, 0);
    endtask

    task automatic align();
        if ((cyc % TICK_PERIOD) == TICK_PERIOD - 1) apply_stimulus(1'b0, 0, 0);
    endtask

    task automatic request(input int ch, input int len);
        align();
        apply_stimulus(1'b1, ch, len);
    endtask

    task automatic clear_meas();
        for (int i = 0; i < NCH; i++) en_ticks[i] = 0;
        drop_seen = 0;
    endtask

    initial begin
        reset_n = 1'b0; audio_clk_en = 1'b0; trig_valid = 1'b0; trig_ch = '0; trig_len = '0;
        trig_valid5 = 1'b0; trig_ch5 = '0; trig_len5 = '0;
        clear_meas();
        model_reset();
        @(posedge clk);
        #2;
        check_output("reset_en", en, 0);
        check_output("reset_drop", trig_drop, 0);
        check_output("reset_active", active_count, 0);
        check_output("reset_ready", trig_ready, 0);
        cmp_en = 1'b1;
        run_idle(2);
        reset_n = 1'b1;
        run_idle(3);

        // Default-length one-shot
        clear_meas();
        request(1, 0);
        check_output("s1_en_rise", en, 4'b0010);
        check_output("s1_active_on", active_count, 1);
        run_idle(14 * TICK_PERIOD);
        check_output("s1_on_ticks", en_ticks[1], 10);
        check_output("s1_active_end", active_count, 0);

        // Retrigger mid-ON
        clear_meas();
        request(2, 5);
        run_idle(2 * TICK_PERIOD);
        check_output("s2_first_ticks", en_ticks[2], 2);
        request(2, 4);
        check_output("s2_en_fall", en[2], 0);
        check_output("s2_reserved", active_count, 1);
        clear_meas();
        run_idle(10 * TICK_PERIOD);
        check_output("s2_second_ticks", en_ticks[2], 4);
        check_output("s2_no_drop", drop_seen, 0);

`ifdef DK_SFX_PREEMPT_EN
        request(2, 30);
        request(3, 30);
        request(0, 5);
        check_output("s4_victim_en", en, 4'b0101);
        check_output("s4_no_drop", trig_drop, 0);
        check_output("s4_active", active_count, 2);
        request(3, 5);
        check_output("s4_no_victim_drop", trig_drop, 1);
`else
        request(0, 30);
        request(1, 30);
        request(3, 5);
        check_output("s3_drop", trig_drop, 1);
        check_output("s3_en", en, 4'b0011);
        check_output("s3_active", active_count, 2);
        run_idle(1);
        check_output("s3_drop_1cyc", trig_drop, 0);
`endif
        run_idle(40 * TICK_PERIOD);

        // Pending length overwritten during one GAP
        request(0, 3);
        run_idle(TICK_PERIOD);
        request(0, 6);
        request(0, 2);
        clear_meas();
        run_idle(6 * TICK_PERIOD);
        check_output("s6_overwrite_ticks", en_ticks[0], 2);

        // Valid held across a tick, then reset mid-ON
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 2, 3);
        run_idle(12 * TICK_PERIOD);
        request(1, 20);
        run_idle(10);
        check_output("s5_on_before_reset", en[1], 1);
        reset_n = 1'b0;
        #1;
        check_output("s5_async_en", en, 0);
        check_output("s5_async_active", active_count, 0);
        check_output("s5_ready_in_reset", trig_ready, 0);
        run_idle(3);
        reset_n = 1'b1;
        check_output("s5_post_active", active_count, 0);
        run_idle(2);

        // Out-of-range channel on the five-channel variant
        align();
        trig_valid5 = 1'b1; trig_ch5 = 3'd5; trig_len5 = 16'd3;
        apply_stimulus(1'b0, 0, 0);
        trig_valid5 = 1'b0;
        check_output("oor5_drop", trig_drop5, 1);
        check_output("oor5_en", en5, 0);
        check_output("oor5_active", active_count5, 0);
        align();
        trig_valid5 = 1'b1; trig_ch5 = 3'd7; trig_len5 = 16'd0;
        apply_stimulus(1'b0, 0, 0);
        trig_valid5 = 1'b0;
        check_output("oor7_drop", trig_drop5, 1);
        align();
        trig_valid5 = 1'b1; trig_ch5 = 3'd4; trig_len5 = 16'd0;
        apply_stimulus(1'b0, 0, 0);
        trig_valid5 = 1'b0;
        check_output("ch4_en", en5, 5'b10000);
        check_output("ch4_active", active_count5, 1);
        check_output("ch4_no_drop", trig_drop5, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            bit v = ($urandom_range(0, 2) == 0);
            int ch = int'($urandom_range(0, NCH - 1));
            int len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
            apply_stimulus(v, ch, len);
        end
        run_idle(20 * TICK_PERIOD);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
